// File: rtl/wiener_pkg.sv
// wiener_pkg: shared state encoding and default sizing for the Wiener filter frame scheduler.
package wiener_pkg;
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_COL_NUM = 96;
    localparam int DEF_ROW_NUM = 2;
    localparam int COEF_NUM    = DEF_COL_NUM * DEF_ROW_NUM;
    localparam int DEF_DATA_AW = 17;
    localparam int DEF_COEF_AW = 10;
    localparam int DEF_TIMEOUT = 4096;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_GAP,
        S_START,
        S_WAIT
    } state_t;
endpackage

// File: rtl/wiener_frame_sched_if.sv
// wiener_frame_sched_if: host coefficient bus, feature stream and filter RAM/control ports of the scheduler.
interface wiener_frame_sched_if
    import wiener_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DATA_AW = DEF_DATA_AW,
    parameter int COEF_AW = DEF_COEF_AW
);
    logic               coef_wr_i;
    logic [COEF_AW-1:0] coef_addr_i;
    logic [WIDTH-1:0]   coef_data_i;
    logic               coef_ready_o;
    logic               feat_valid_i;
    logic [WIDTH-1:0]   feat_data_i;
    logic               feat_last_i;
    logic               feat_ready_o;
    logic               wf_ram_wr_en_o;
    logic [COEF_AW-1:0] wf_wr_addr_o;
    logic [WIDTH-1:0]   wf_ram_data_o;
    logic               wf_data_wr_en_o;
    logic [DATA_AW-1:0] wf_data_addr_o;
    logic [WIDTH-1:0]   wf_data_o;
    logic               wf_start_o;
    logic               wf_finish_i;
    logic               coef_valid_o;
    logic               busy_o;
    logic               frame_done_o;
    logic [31:0]        frame_cnt_o;
    logic               err_len_o;
    logic               err_tmo_o;
    logic               err_clr_i;

    modport slave (
        input  coef_wr_i, coef_addr_i, coef_data_i, feat_valid_i, feat_data_i, feat_last_i,
               wf_finish_i, err_clr_i,
        output coef_ready_o, feat_ready_o, wf_ram_wr_en_o, wf_wr_addr_o, wf_ram_data_o,
               wf_data_wr_en_o, wf_data_addr_o, wf_data_o, wf_start_o, coef_valid_o, busy_o,
               frame_done_o, frame_cnt_o, err_len_o, err_tmo_o
    );

    modport master (
        output coef_wr_i, coef_addr_i, coef_data_i, feat_valid_i, feat_data_i, feat_last_i,
               wf_finish_i, err_clr_i,
        input  coef_ready_o, feat_ready_o, wf_ram_wr_en_o, wf_wr_addr_o, wf_ram_data_o,
               wf_data_wr_en_o, wf_data_addr_o, wf_data_o, wf_start_o, coef_valid_o, busy_o,
               frame_done_o, frame_cnt_o, err_len_o, err_tmo_o
    );
endinterface

// File: rtl/wiener_frame_cnt.sv
// wiener_frame_cnt: per-frame beat address counter with frame length classification.
module wiener_frame_cnt
    import wiener_pkg::*;
#(
    parameter int COL_NUM = DEF_COL_NUM,
    parameter int KW      = $clog2(COL_NUM + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          beat_i,
    input  logic          last_i,
    output logic [KW-1:0] addr_o,
    output logic          wr_o,
    output logic          ok_o,
    output logic          short_o,
    output logic          over_o,
    output logic          end_o
);
    logic [KW-1:0] k_q, k_d;
    logic          drop_q, drop_d;
    logic          at_end;

    // Once a frame overruns, drop_q swallows beats without writing until last
    always_comb begin
        at_end  = k_q == KW'(COL_NUM - 1);
        wr_o    = beat_i & ~drop_q;
        ok_o    = wr_o & at_end & last_i;
        short_o = wr_o & ~at_end & last_i;
        over_o  = wr_o & at_end & ~last_i;
        end_o   = beat_i & last_i;
        addr_o  = k_q;
        k_d     = (~beat_i | drop_q) ? k_q : (last_i | at_end) ? '0 : k_q + 1'b1;
        drop_d  = beat_i ? (~last_i & (drop_q | at_end)) : drop_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q    <= '0;
            drop_q <= 1'b0;
        end else begin
            k_q    <= k_d;
            drop_q <= drop_d;
        end
    end
endmodule

// File: rtl/wiener_frame_sched.sv
// wiener_frame_sched: serialises host coefficient loads and per-frame feature writes into the
// Wiener filter RAMs, then starts the filter and waits, bounded by TIMEOUT, for its finish pulse.
module wiener_frame_sched
    import wiener_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int COL_NUM = DEF_COL_NUM,
    parameter int ROW_NUM = DEF_ROW_NUM,
    parameter int DATA_AW = DEF_DATA_AW,
    parameter int COEF_AW = DEF_COEF_AW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    wiener_frame_sched_if.slave bus
);
    localparam int COEF_N = COL_NUM * ROW_NUM;
    localparam int CCW    = $clog2(COEF_N + 1);
    localparam int TCW    = $clog2(TIMEOUT + 1);
    localparam int KW     = $clog2(COL_NUM + 1);

    state_t             state_q, state_d;
    logic [CCW-1:0]     ccnt_q, ccnt_d;
    logic               cvalid_q, cvalid_d;
    logic [TCW-1:0]     tcnt_q, tcnt_d;
    logic               dwr_q, dwr_d;
    logic [DATA_AW-1:0] daddr_q, daddr_d;
    logic [WIDTH-1:0]   ddat_q, ddat_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        fcnt_q, fcnt_d;
    logic               elen_q, elen_d;
    logic               etmo_q, etmo_d;

    logic          coef_ready, coef_acc, feat_ready, beat, fin, tmo;
    logic [KW-1:0] fc_addr;
    logic          fc_wr, fc_ok, fc_short, fc_over, fc_end;

    wiener_frame_cnt #(.COL_NUM(COL_NUM), .KW(KW)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .beat_i (beat),
        .last_i (bus.feat_last_i),
        .addr_o (fc_addr),
        .wr_o   (fc_wr),
        .ok_o   (fc_ok),
        .short_o(fc_short),
        .over_o (fc_over),
        .end_o  (fc_end)
    );

    // Gating ready with rst_n keeps every output low while reset is held
    always_comb begin
        coef_ready = rst_n & (state_q == S_IDLE);
        coef_acc   = bus.coef_wr_i & coef_ready;
        feat_ready = cvalid_q & ~bus.coef_wr_i & (state_q == S_IDLE | state_q == S_FILL);
        beat       = bus.feat_valid_i & feat_ready;
        fin        = (state_q == S_WAIT) & bus.wf_finish_i;
        tmo        = (state_q == S_WAIT) & ~bus.wf_finish_i & (tcnt_q == TCW'(TIMEOUT - 1));
        state_d    = fc_ok ? S_GAP :
                     fc_end ? S_IDLE :
                     beat ? S_FILL :
                     (state_q == S_GAP) ? S_START :
                     (state_q == S_START) ? S_WAIT :
                     (fin | tmo) ? S_IDLE : state_q;
        tcnt_d     = (state_q == S_WAIT) ? tcnt_q + 1'b1 : '0;
        ccnt_d     = ~coef_acc ? ccnt_q : cvalid_q ? CCW'(1) : ccnt_q + 1'b1;
        cvalid_d   = coef_acc ? (~cvalid_q & (ccnt_q == CCW'(COEF_N - 1))) : cvalid_q;
        dwr_d      = fc_wr;
        daddr_d    = fc_wr ? DATA_AW'(fc_addr) : '0;
        ddat_d     = fc_wr ? bus.feat_data_i : '0;
        start_d    = state_q == S_START;
        busy_d     = state_d != S_IDLE;
        done_d     = fin;
        fcnt_d     = fcnt_q + 32'(fin);
        elen_d     = ~bus.err_clr_i & (elen_q | fc_short | fc_over);
        etmo_d     = ~bus.err_clr_i & (etmo_q | tmo);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ccnt_q   <= '0;
            cvalid_q <= 1'b0;
            tcnt_q   <= '0;
            dwr_q    <= 1'b0;
            daddr_q  <= '0;
            ddat_q   <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fcnt_q   <= '0;
            elen_q   <= 1'b0;
            etmo_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ccnt_q   <= ccnt_d;
            cvalid_q <= cvalid_d;
            tcnt_q   <= tcnt_d;
            dwr_q    <= dwr_d;
            daddr_q  <= daddr_d;
            ddat_q   <= ddat_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fcnt_q   <= fcnt_d;
            elen_q   <= elen_d;
            etmo_q   <= etmo_d;
        end
    end

    assign bus.coef_ready_o    = coef_ready;
    assign bus.wf_ram_wr_en_o  = coef_acc;
    assign bus.wf_wr_addr_o    = coef_acc ? bus.coef_addr_i : '0;
    assign bus.wf_ram_data_o   = coef_acc ? bus.coef_data_i : '0;
    assign bus.feat_ready_o    = feat_ready;
    assign bus.wf_data_wr_en_o = dwr_q;
    assign bus.wf_data_addr_o  = daddr_q;
    assign bus.wf_data_o       = ddat_q;
    assign bus.wf_start_o      = start_q;
    assign bus.coef_valid_o    = cvalid_q;
    assign bus.busy_o          = busy_q;
    assign bus.frame_done_o    = done_q;
    assign bus.frame_cnt_o     = fcnt_q;
    assign bus.err_len_o       = elen_q;
    assign bus.err_tmo_o       = etmo_q;
endmodule
